// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register feeding a 2-entry {instruction, pc} buffer
// that presents its head to decode, with branch redirect and synchronous reset.
module fetch_stage #(
    parameter int          WIDTH   = 8,
    parameter int unsigned RESETPC = 0,
    parameter int unsigned INCR    = 1
) (
    input  logic             clock,
    input  logic             reset,
    output logic [WIDTH-1:0] instrAddress,
    input  logic [WIDTH-1:0] instrData,
    input  logic             branchTaken,
    input  logic [WIDTH-1:0] branchTarget,
    input  logic             decodeReady,
    output logic [WIDTH-1:0] instructionD,
    output logic [WIDTH-1:0] pcD,
    output logic [WIDTH-1:0] pcPlus8D,
    output logic             validD,
    output logic [1:0]       count
);

    localparam logic [WIDTH-1:0] L_RESETPC = WIDTH'(RESETPC);
    localparam logic [WIDTH-1:0] L_INCR    = WIDTH'(INCR);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_pc;
    logic             r_head;
    logic [WIDTH-1:0] r_instr [2];
    logic [WIDTH-1:0] r_pcbuf [2];

    logic w_pop;
    logic w_push;
    logic w_tail;

    assign w_pop  = validD & decodeReady;
    assign w_push = !branchTaken & ((r_state != S_FULL) | w_pop);
    // When FULL and popping, the slot being vacated is the head, so the tail lands there.
    assign w_tail = (r_state == S_ONE) ? ~r_head : r_head;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_EMPTY;
            r_pc    <= L_RESETPC;
            r_head  <= 1'b0;
        end else if (branchTaken) begin
            r_state <= S_EMPTY;
            r_pc    <= branchTarget;
            r_head  <= 1'b0;
        end else begin
            if (w_push)
                r_pc <= r_pc + L_INCR;
            if (w_pop)
                r_head <= ~r_head;
            case ({w_push, w_pop})
                2'b10:   r_state <= (r_state == S_EMPTY) ? S_ONE : S_FULL;
                2'b01:   r_state <= (r_state == S_FULL) ? S_ONE : S_EMPTY;
                default: r_state <= r_state;
            endcase
        end
    end

    // Buffer contents need no reset: occupancy alone decides what is visible.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_instr[w_tail] <= instrData;
            r_pcbuf[w_tail] <= r_pc;
        end
    end

    assign instrAddress = r_pc;
    assign validD       = (r_state != S_EMPTY);
    assign instructionD = validD ? r_instr[r_head] : '0;
    assign pcD          = validD ? r_pcbuf[r_head] : '0;
    assign pcPlus8D     = pcD + WIDTH'(8);
    assign count        = 2'(r_state);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: streaming, backpressure, redirect, wrap and reset cases.
module tb_fetch_stage;

    logic       clock = 1'b0;
    logic       reset;
    logic       branchTaken;
    logic [7:0] branchTarget;
    logic       decodeReady;

    logic [7:0] instrAddress, instrData, instructionD, pcD, pcPlus8D;
    logic       validD;
    logic [1:0] count;

    logic [7:0] w_addr, w_data, w_instrD, w_pcD, w_pc8D;
    logic       w_validD;
    logic [1:0] w_count;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clock = ~clock;

    // Instruction memory model: memory[i] = i + 0x10
    assign instrData = instrAddress + 8'h10;
    assign w_data    = w_addr + 8'h10;

    fetch_stage #(.WIDTH(8), .RESETPC(0), .INCR(1)) dut (
        .clock(clock), .reset(reset), .instrAddress(instrAddress), .instrData(instrData),
        .branchTaken(branchTaken), .branchTarget(branchTarget), .decodeReady(decodeReady),
        .instructionD(instructionD), .pcD(pcD), .pcPlus8D(pcPlus8D), .validD(validD), .count(count)
    );

    fetch_stage #(.WIDTH(8), .RESETPC(8'hFE), .INCR(1)) dut_wrap (
        .clock(clock), .reset(reset), .instrAddress(w_addr), .instrData(w_data),
        .branchTaken(branchTaken), .branchTarget(branchTarget), .decodeReady(decodeReady),
        .instructionD(w_instrD), .pcD(w_pcD), .pcPlus8D(w_pc8D), .validD(w_validD), .count(w_count)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
        $display("[TB] %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; branchTaken = 1'b0; branchTarget = 8'h00; decodeReady = 1'b0;
        tick(); tick();

        // Reset state
        check("rst_count", count, 0);
        check("rst_valid", validD, 0);
        check("rst_addr", instrAddress, 0);
        check("rst_instr", instructionD, 0);
        check("rst_pcD", pcD, 0);
        check("rst_pc8", pcPlus8D, 8);
        check("rst_wrap_addr", w_addr, 8'hFE);

        // Streaming with decodeReady held high; wrap instance runs the same stimulus
        reset = 1'b0; decodeReady = 1'b1;
        #1;
        check("stream_c0_valid", validD, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("stream%0d_valid", i), validD, 1);
            check($sformatf("stream%0d_count", i), count, 1);
            check($sformatf("stream%0d_instr", i), instructionD, 8'h10 + i);
            check($sformatf("stream%0d_pcD", i), pcD, i);
            check($sformatf("stream%0d_pc8", i), pcPlus8D, 8 + i);
            check($sformatf("wrap%0d_pcD", i), w_pcD, (8'hFE + i) & 8'hFF);
            check($sformatf("wrap%0d_pc8", i), w_pc8D, (8'h06 + i) & 8'hFF);
        end

        // Backpressure from a fresh reset
        reset = 1'b1; tick();
        reset = 1'b0; decodeReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("bp%0d_count", i), count, (i == 0) ? 1 : 2);
            check($sformatf("bp%0d_instr", i), instructionD, 8'h10);
        end
        check("bp_addr", instrAddress, 2);

        // Simultaneous push/pop at FULL for one cycle
        decodeReady = 1'b1;
        tick();
        decodeReady = 1'b0;
        #1;
        check("pp_count", count, 2);
        check("pp_instr", instructionD, 8'h11);
        check("pp_pcD", pcD, 1);
        check("pp_addr", instrAddress, 3);

        // Release: continue in order, no loss or duplicate
        decodeReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("rel%0d_instr", i), instructionD, 8'h12 + i);
            check($sformatf("rel%0d_count", i), count, 2);
        end

        // Redirect while FULL
        decodeReady = 1'b0;
        tick();
        check("pre_br_count", count, 2);
        branchTaken = 1'b1; branchTarget = 8'h40;
        tick();
        branchTaken = 1'b0; decodeReady = 1'b1;
        #1;
        check("br_count", count, 0);
        check("br_valid", validD, 0);
        check("br_addr", instrAddress, 8'h40);
        check("br_pc8_empty", pcPlus8D, 8);
        tick();
        check("br_instr", instructionD, 8'h50);
        check("br_pcD", pcD, 8'h40);
        check("br_pc8", pcPlus8D, 8'h48);
        check("br_count1", count, 1);

        // Consecutive redirects: last target wins
        branchTaken = 1'b1; branchTarget = 8'h20;
        tick();
        branchTarget = 8'h30;
        tick();
        check("br2_addr", instrAddress, 8'h30);
        check("br2_valid", validD, 0);
        branchTaken = 1'b0;
        tick();
        check("br2_pcD", pcD, 8'h30);
        check("br2_instr", instructionD, 8'h40);

        // Reset mid-stream overrides a simultaneous redirect
        decodeReady = 1'b0;
        tick();
        check("mid_count", count, 2);
        reset = 1'b1; branchTaken = 1'b1; branchTarget = 8'h40;
        tick();
        check("mrst_count", count, 0);
        check("mrst_valid", validD, 0);
        check("mrst_addr", instrAddress, 0);
        reset = 1'b0; branchTaken = 1'b0; decodeReady = 1'b1;
        tick();
        check("mrst_first_pcD", pcD, 0);
        check("mrst_first_instr", instructionD, 8'h10);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The module SHALL take parameter WIDTH, default 8, data and address width.
REQ-002 The module SHALL take parameter RESETPC, default 0, the PC value loaded on reset.
REQ-003 The module SHALL take parameter INCR, default 1, the PC step per fetched instruction.
REQ-004 The module SHALL have port clock  in  1  single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 The module SHALL have port instrAddress  out  WIDTH  fetch PC driven to instruction memory.
REQ-007 The module SHALL have port instrData  in  WIDTH  memory word at instrAddress, valid in the same cycle.
REQ-008 The module SHALL have port branchTaken  in  1  redirect request from a later stage.
REQ-009 The module SHALL have port branchTarget  in  WIDTH  redirect PC, sampled when branchTaken=1.
REQ-010 The module SHALL have port decodeReady  in  1  decode accepts the presented instruction this cycle.
REQ-011 The module SHALL have port instructionD  out  WIDTH  instruction presented to decode.
REQ-012 The module SHALL have port pcD  out  WIDTH  PC of instructionD.
REQ-013 The module SHALL have port pcPlus8D  out  WIDTH  pcD+8 modulo 2^WIDTH, used as R1 operand by decode.
REQ-014 The module SHALL have port validD  out  1  instructionD/pcD/pcPlus8D hold a real instruction.
REQ-015 The module SHALL have port count  out  2  buffer occupancy, 0..2.

Function
REQ-016 The block SHALL hold a PC register and a 2-entry FIFO of {instruction, pc} pairs; instrAddress SHALL equal the PC register.
REQ-017 Occupancy FSM SHALL have states EMPTY(0), ONE(1), FULL(2); count SHALL encode the state.
REQ-018 pop SHALL be validD & decodeReady; push SHALL be !branchTaken & (state!=FULL | pop).
REQ-019 On push, {instrData, PC} SHALL be written to the FIFO tail and PC SHALL become PC+INCR modulo 2^WIDTH (wrap 2^WIDTH-1 -> 0 silently).
REQ-020 Without push, PC SHALL hold, except on redirect.
REQ-021 Transitions: push&!pop -> +1; pop&!push -> -1; push&pop -> unchanged (including FULL); neither -> unchanged.
REQ-022 Outputs SHALL reflect the FIFO head combinationally from registered state; fetch-to-decode latency SHALL be 1 cycle when EMPTY.
REQ-023 validD SHALL be 1 iff state!=EMPTY; when EMPTY, instructionD, pcD SHALL be 0 and pcPlus8D SHALL be 8.
REQ-024 Head outputs SHALL stay stable while validD=1 and decodeReady=0.
REQ-025 branchTaken=1 SHALL, at the next edge, set state to EMPTY, PC to branchTarget, and suppress push that cycle, regardless of pop or occupancy.
REQ-026 An instruction presented with decodeReady=1 in the redirect cycle SHALL count as consumed; no other buffered instruction SHALL be presented after a redirect.
REQ-027 branchTaken on consecutive cycles SHALL each redirect; the last target wins.
REQ-028 pop while EMPTY SHALL be impossible by construction (validD=0); count SHALL never exceed 2 or underflow.

Reset
REQ-029 reset=1 at an edge SHALL set PC=RESETPC, state=EMPTY, FIFO contents irrelevant, overriding branchTaken and decodeReady.
REQ-030 After reset deassertion, first push SHALL occur at the first edge with reset=0, fetching address RESETPC.
REQ-031 Reset asserted mid-operation SHALL discard all buffered instructions; validD=0 in the cycle after the reset edge.

Verification
REQ-032 Streaming: memory[i]=i+0x10, decodeReady=1 after reset -> validD=1 from cycle 1, instructionD=0x10,0x11,0x12..., pcD=0,1,2, pcPlus8D=8,9,10, count=1.
REQ-033 Backpressure: decodeReady=0 for 4 cycles -> count 1,2,2,2; instrAddress stops at 2; instructionD held 0x10; release -> 0x10,0x11,0x12 in order, no loss or duplicate.
REQ-034 Redirect when FULL: count=2, branchTaken=1, branchTarget=0x40 -> next cycle count=0, validD=0, instrAddress=0x40; following cycle instructionD=memory[0x40], pcD=0x40, pcPlus8D=0x48.
REQ-035 Wrap: RESETPC=0xFE, decodeReady=1 -> pcD sequence 0xFE,0xFF,0x00; pcPlus8D 0x06,0x07,0x08.
REQ-036 Reset mid-stream: count=2, reset=1 with branchTaken=1, branchTarget=0x40 -> next cycle count=0, validD=0, instrAddress=RESETPC.
REQ-037 Simultaneous push/pop at FULL: decodeReady=1 for one cycle -> count stays 2, head advances by one, PC advances by INCR.
